// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the instruction-fetch blocks.
`default_nettype none

package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam int          IMEM_AW          = 11;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry synchronous FIFO of {instr, pc} with clear and head output.
// Revision 1.0
`default_nettype none

module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch PC, memory enable/address and redirect handling in front of ifetch_queue.
// Optional IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs. Revision 1.0
`default_nettype none

module ifetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rena,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int             CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_offset;
  logic [CW-1:0] count;
  logic          fetch;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  new_entry;
  logic          unused_bits;

  // Full test uses registered count only, so id_ready never reaches imem_rena.
  assign fetch     = !rst && !redirect_valid && (count != FULL_COUNT);
  assign imem_rena = fetch;
  assign pc_offset = fetch_pc - RESET_PC;
  assign imem_addr = pc_offset[12:2];

  assign if_valid  = !rst && (count != '0);
  assign pop       = if_valid && id_ready && !redirect_valid;
  assign if_instr  = if_valid ? head.instr : NOP;
  assign if_pc     = if_valid ? head.pc    : '0;

  assign new_entry = '{instr: imem_rdata, pc: fetch_pc};

  // Offset bits outside the word index alias away, as do the redirect byte bits.
  assign unused_bits = &{1'b0, pc_offset[31:13], pc_offset[1:0], redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (fetch) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  ifetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .push       (fetch),
    .push_entry (new_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!if_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and random stimulus for ifetch_ctrl against a queue-based fetch model.
`default_nettype none

module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rena;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return 32'h1000_0000 + {21'd0, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  ifetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rena      (imem_rena),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic        known = 1'b0;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  int vectors    = 0;
  int miscompares = 0;

  logic        s_rena, s_valid;
  logic [10:0] s_addr;
  logic [31:0] s_instr, s_pc, s_pfetch, s_pstall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic        e_fetch, e_valid;
    logic [31:0] off;
    logic [10:0] e_addr;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; id_ready = rdy;
    #1;
    e_fetch = !r && !rv && (mq.size() < DEPTH);
    e_valid = !r && (mq.size() > 0);
    off     = mpc - RESET_PC;
    e_addr  = off[12:2];
    chk("rena",  {31'd0, imem_rena}, {31'd0, e_fetch});
    chk("valid", {31'd0, if_valid},  {31'd0, e_valid});
    chk("instr", if_instr, e_valid ? mq[0].instr : 32'd0);
    chk("pc",    if_pc,    e_valid ? mq[0].pc    : 32'd0);
    if (known) chk("addr", {21'd0, imem_addr}, {21'd0, e_addr});
`ifdef IFETCH_PERF_EN
    if (known) begin
      chk("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
      chk("perf_stall", perf_stall_cnt, m_stall_cnt);
    end
    s_pfetch = perf_fetch_cnt; s_pstall = perf_stall_cnt;
`else
    s_pfetch = '0; s_pstall = '0;
`endif
    s_rena = imem_rena; s_valid = if_valid; s_addr = imem_addr;
    s_instr = if_instr; s_pc = if_pc;
    if (r) begin
      mq.delete();
      mpc = RESET_PC; known = 1'b1;
      m_fetch_cnt = '0; m_stall_cnt = '0;
    end else begin
      if (!e_valid) m_stall_cnt++;
      if (rv) begin
        mq.delete();
        mpc = {rp[31:2], 2'b00};
      end else begin
        if (e_valid && rdy) void'(mq.pop_front());
        if (e_fetch) begin
          mq.push_back('{instr: mem_word(e_addr), pc: mpc});
          mpc = mpc + 32'd4;
          m_fetch_cnt++;
        end
      end
    end
  endtask

  int pushes;
  int thr;

  initial begin
    // Reset, then streaming from RESET_PC.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_rena",  {31'd0, s_rena},  32'd0);
    chk("rst_pc",    s_pc, 32'd0);
    step(0, 0, 0, 1);
    chk("first_rena", {31'd0, s_rena}, 32'd1);
    chk("first_addr", {21'd0, s_addr}, 32'd0);
    chk("first_valid", {31'd0, s_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("head0_pc",    s_pc,    32'h0040_0000);
    chk("head0_instr", s_instr, 32'h1000_0000);
    step(0, 0, 0, 1);
    chk("head1_pc",    s_pc,    32'h0040_0004);
    chk("head1_instr", s_instr, 32'h1000_0001);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
`ifdef IFETCH_PERF_EN
    chk("perf_fetch_5", s_pfetch, 32'd5);
    chk("perf_stall_1", s_pstall, 32'd1);
`endif

    // Fill from empty with decode stalled.
    step(0, 1, 32'h0040_0200, 0);
    pushes = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      pushes += int'(s_rena);
    end
    chk("fill_pushes", pushes, 4);
    chk("full_rena", {31'd0, s_rena}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      chk("drain_pc",    s_pc,    32'h0040_0200 + 32'(4 * i));
      chk("drain_instr", s_instr, 32'h1000_0080 + 32'(i));
      if (i == 0) chk("drain_rena0", {31'd0, s_rena}, 32'd0);
      if (i == 1) chk("drain_rena1", {31'd0, s_rena}, 32'd1);
    end

    // Redirect with entries queued; low byte bits dropped.
    step(0, 1, 32'h0040_0103, 1);
    step(0, 0, 0, 1);
    chk("redir_valid", {31'd0, s_valid}, 32'd0);
    chk("redir_addr",  {21'd0, s_addr},  32'h040);
    chk("redir_rena",  {31'd0, s_rena},  32'd1);
    step(0, 0, 0, 1);
    chk("redir_pc",    s_pc,    32'h0040_0100);
    chk("redir_instr", s_instr, 32'h1000_0040);

    // Redirect while full and decode ready: nothing from the old stream survives.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0040_0800, 1);
    step(0, 0, 0, 1);
    chk("fullredir_valid", {31'd0, s_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("fullredir_pc", s_pc, 32'h0040_0800);

    // Single-cycle reset mid-stream.
    step(1, 0, 0, 1);
    chk("midrst_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_instr", s_instr, 32'd0);
    chk("midrst_rena",  {31'd0, s_rena}, 32'd0);
    step(0, 0, 0, 1);
    chk("midrst_addr", {21'd0, s_addr}, 32'd0);
    step(0, 0, 0, 1);
    chk("midrst_pc", s_pc, RESET_PC);

    // Fetch PC wraps through 2^32.
    step(0, 1, 32'hFFFF_FFF9, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Random traffic.
    thr = 7;
    for (int i = 0; i < 2000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rp;
      if (i % 100 == 0) thr = $urandom_range(10);
      r   = ($urandom_range(99) == 0);
      rv  = ($urandom_range(19) == 0);
      rp  = ($urandom_range(3) == 0) ? $urandom() : RESET_PC + $urandom_range(16383);
      rdy = ($urandom_range(9) < thr);
      step(r, rv, rp, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller sitting between the pipeline's decode stage and the instruction memory (11-bit word address, 32-bit combinational read). It owns the fetch PC, drives the memory's read enable and address, and buffers fetched words with their PCs in a small queue. This decouples fetch from decode stalls and lets the pipeline redirect fetch on branches, jumps and exceptions.

## Interface
- RESET_PC, 32'h0040_0000: byte address fetched first after reset; also the base mapped to memory word 0.
- DEPTH, 4: queue entries; must be a power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_rena  out  1  read enable to instruction memory.
- imem_addr  out  11  word address to instruction memory.
- imem_rdata  in  32  instruction word returned in the same cycle.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch byte address; bits [1:0] ignored, treated as 0.
- id_ready  in  1  decode accepts the head entry this cycle.
- if_valid  out  1  head entry present.
- if_instr  out  32  head instruction; 0 when if_valid=0.
- if_pc  out  32  head byte PC; 0 when if_valid=0.

## Operation
- State: fetch_pc (32 b), queue of DEPTH entries {instr, pc}, wr_ptr, rd_ptr, count (log2(DEPTH)+1 b).
- Fetch enable: fetch = !rst && !redirect_valid && (count < DEPTH). imem_rena = fetch. Full-queue decision uses registered count only; no combinational path from id_ready to imem_rena.
- imem_addr = (fetch_pc − RESET_PC)[12:2]. It is driven even when rena=0. Offsets beyond 8 KiB alias modulo 2048 words.
- Push: when fetch=1, write {imem_rdata, fetch_pc} at wr_ptr; wr_ptr+1; fetch_pc += 4, with 32-bit wrap.
- Pop: when if_valid && id_ready && !redirect_valid, advance rd_ptr.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect: same-cycle clear of the queue (count, wr_ptr, rd_ptr ← 0) and fetch_pc ← {redirect_pc[31:2],2'b00}. There is no push, and any pop is discarded. Redirect has priority over everything except rst.
- Reset: fetch_pc ← RESET_PC; count, pointers ← 0. Queue storage is not required to clear. Outputs while rst=1: imem_rena=0, if_valid=0, if_instr=0, if_pc=0. Reset mid-stream discards all queued entries.

## Timing
- Fetch-to-visible latency is 1 cycle: a word pushed in cycle N appears at the head in N+1 if the queue was empty.
- First cycle with rst=0: rena=1, addr=0. Next cycle: if_valid=1, if_pc=RESET_PC.
- Steady state with id_ready=1 held: one instruction per cycle; count stays at 1.
- With id_ready=0: queue fills to DEPTH after DEPTH fetch cycles, then rena=0. After a pop from full, fetch resumes the following cycle.
- Redirect in cycle N: if_valid=0 in N+1, rena=1 in N+1 at the new address, and the new head is visible in N+2.

## Configuration
- IFETCH_PERF_EN defined adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt counts push cycles.
  - perf_stall_cnt counts cycles with rst=0 and if_valid=0.
  - Both reset to 0 and wrap; redirect does not clear them.
- IFETCH_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg holds RESET_PC default, IMEM_AW=11, XLEN=32, and the NOP encoding 32'h0000_0000.
- One sub-module, ifetch_queue: DEPTH-entry synchronous FIFO of {instr, pc} with push, pop, clear, count, and a head output. ifetch_ctrl holds fetch_pc, the enable logic and the perf counters.

## Test plan
- Reset release, imem word k = 32'h1000_0000+k, id_ready=1 → if_pc sequence 0x00400000, 0x00400004, …; if_instr 0x10000000, 0x10000001, …; if_valid=1 from the 2nd cycle onward.
- id_ready=0 for 10 cycles → exactly 4 pushes, then rena=0. Raising id_ready yields 4 buffered words in order, then continuous flow with no gap or duplicate.
- redirect_valid pulse with redirect_pc=0x00400103 while 3 entries are queued → next cycle if_valid=0, imem_addr=0x040; following cycle if_pc=0x00400100.
- redirect_valid asserted in the same cycle as id_ready=1 with the queue full → no entry is popped or delivered; the only next instructions come from the new PC.
- rst asserted for 1 cycle mid-stream → all outputs 0 during reset; restart at RESET_PC with the queue empty.
- With IFETCH_PERF_EN: after reset, 5 fetches with id_ready=1 → perf_fetch_cnt=5, perf_stall_cnt=1 (the first cycle).
